wb_commit_trace_fifo: RTL and testbench

//  Collects the two per-cycle write-back channels of the dual-issue datapath (lane 0, lane 1).

---
 rtl/wb_commit_trace_fifo.sv | 113 +++++++++++
 tb/tb_wb_commit_trace_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_trace_fifo.sv
// Dual-lane write-back trace collector: merges lane 0 / lane 1 commits into one in-order record stream.
// Optional build macro WB_TRACE_SKIP_ZERO_EN: writes to rd == 0 are not recorded.
module wb_commit_trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in0_en,
  input  logic [4:0]                 in0_rd,
  input  logic [DATA_W-1:0]          in0_wdata,
  input  logic [PC_W-1:0]            in0_pc,
  input  logic                       in1_en,
  input  logic [4:0]                 in1_rd,
  input  logic [DATA_W-1:0]          in1_wdata,
  input  logic [PC_W-1:0]            in1_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [4:0]                 out_rd,
  output logic [DATA_W-1:0]          out_wdata,
  output logic                       out_order,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [4:0]        rd_mem    [DEPTH];
  logic [DATA_W-1:0] wdata_mem [DEPTH];
  logic              order_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          lane0_en, lane1_en;
  logic [CW-1:0] n_push;
  logic [CW-1:0] free_slots;
  logic          push_drop, push_acc, pop;
  logic [AW-1:0] wr_addr0, wr_addr1;

  always_comb begin
    lane0_en = in0_en;
    lane1_en = in1_en;
`ifdef WB_TRACE_SKIP_ZERO_EN
    lane0_en = in0_en && (in0_rd != 5'd0);
    lane1_en = in1_en && (in1_rd != 5'd0);
`endif
    n_push     = {{(CW-1){1'b0}}, lane0_en} + {{(CW-1){1'b0}}, lane1_en};
    // Free space is judged before this cycle's pop, so a pair is dropped whole or kept whole.
    free_slots = DEPTH_C - count_q;
    push_drop  = n_push > free_slots;
    push_acc   = !push_drop && (n_push != '0);
    pop        = (count_q != '0) && out_ready;

    wr_addr0 = wr_ptr_q;
    wr_addr1 = lane0_en ? wr_ptr_q + AW'(1) : wr_ptr_q;

    wr_ptr_d   = push_acc ? wr_ptr_q + AW'(n_push) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + (push_acc ? n_push : '0) - (pop ? CW'(1) : '0);
    overflow_d = overflow_q | push_drop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; only the pointers define what is live.
  always_ff @(posedge clock) begin
    if (!reset && push_acc) begin
      if (lane0_en) begin
        pc_mem[wr_addr0]    <= in0_pc;
        rd_mem[wr_addr0]    <= in0_rd;
        wdata_mem[wr_addr0] <= in0_wdata;
        order_mem[wr_addr0] <= 1'b0;
      end
      if (lane1_en) begin
        pc_mem[wr_addr1]    <= in1_pc;
        rd_mem[wr_addr1]    <= in1_rd;
        wdata_mem[wr_addr1] <= in1_wdata;
        order_mem[wr_addr1] <= 1'b1;
      end
    end
  end

  assign out_pc    = pc_mem[rd_ptr_q];
  assign out_rd    = rd_mem[rd_ptr_q];
  assign out_wdata = wdata_mem[rd_ptr_q];
  assign out_order = order_mem[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign in_ready  = (free_slots >= CW'(2));
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_wb_commit_trace_fifo.sv
// Scoreboard bench for wb_commit_trace_fifo: directed scenarios plus random traffic against a queue model.
module tb_wb_commit_trace_fifo;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        order;
  } rec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          in0_en, in1_en;
  logic [4:0]    in0_rd, in1_rd;
  logic [31:0]   in0_wdata, in1_wdata, in0_pc, in1_pc;
  logic          in_ready, out_valid, out_ready, out_order, overflow;
  logic [31:0]   out_pc, out_wdata;
  logic [4:0]    out_rd;
  logic [CW-1:0] count;

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t exp_q[$];
  int   m_cnt    = 0;
  bit   m_ovf    = 1'b0;
  bit   armed    = 1'b0;
  logic [31:0] pc_ctr = 32'h8000_0000;

  wb_commit_trace_fifo #(.DEPTH(DEPTH), .PC_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .in0_en(in0_en), .in0_rd(in0_rd), .in0_wdata(in0_wdata), .in0_pc(in0_pc),
    .in1_en(in1_en), .in1_rd(in1_rd), .in1_wdata(in1_wdata), .in1_pc(in1_pc),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_wdata(out_wdata), .out_order(out_order),
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a list of records with capacity DEPTH, pairs all-or-nothing.
  always @(posedge clock) begin
    bit e0, e1;
    int n;
    bit popd;
    if (reset) begin
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      e0 = in0_en;
      e1 = in1_en;
`ifdef WB_TRACE_SKIP_ZERO_EN
      if (in0_rd == 5'd0) e0 = 1'b0;
      if (in1_rd == 5'd0) e1 = 1'b0;
`endif
      n    = int'(e0) + int'(e1);
      popd = (m_cnt > 0) && out_ready;
      if (n > DEPTH - m_cnt) m_ovf = 1'b1;
      else begin
        if (e0) exp_q.push_back('{pc: in0_pc, rd: in0_rd, wdata: in0_wdata, order: 1'b0});
        if (e1) exp_q.push_back('{pc: in1_pc, rd: in1_rd, wdata: in1_wdata, order: 1'b1});
        m_cnt += n;
      end
      if (popd) m_cnt--;
    end
  end

  // Monitor: compares status and head record; consumes the expected record on a handshake.
  always @(negedge clock) begin
    rec_t r;
    if (armed) begin
      check("count", 64'(count), 64'(m_cnt));
      check("out_valid", 64'(out_valid), 64'(m_cnt != 0));
      check("in_ready", 64'(in_ready), 64'(DEPTH - m_cnt >= 2));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL head: out_valid=1 but no record expected at %0t", $time);
        end else begin
          r = exp_q[0];
          check("head_pc", 64'(out_pc), 64'(r.pc));
          check("head_rd", 64'(out_rd), 64'(r.rd));
          check("head_wdata", 64'(out_wdata), 64'(r.wdata));
          check("head_order", 64'(out_order), 64'(r.order));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit e0, input logic [31:0] pc0, input logic [4:0] rd0,
                      input logic [31:0] d0, input bit e1, input logic [31:0] pc1,
                      input logic [4:0] rd1, input logic [31:0] d1, input bit rdy, input bit rst);
    in0_en = e0; in0_pc = pc0; in0_rd = rd0; in0_wdata = d0;
    in1_en = e1; in1_pc = pc1; in1_rd = rd1; in1_wdata = d1;
    out_ready = rdy;
    reset = rst;
    @(posedge clock);
    #1;
  endtask

  task automatic rstep(input bit e0, input bit e1, input bit rdy, input bit rst);
    logic [31:0] p;
    p = pc_ctr;
    pc_ctr = pc_ctr + 32'd8;
    step(e0, p, 5'($urandom_range(0, 31)), $urandom,
         e1, p + 32'd4, 5'($urandom_range(0, 31)), $urandom, rdy, rst);
  endtask

  task automatic idle(input bit rdy);
    rstep(1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    rstep(0, 0, 0, 1);
    rstep(0, 0, 0, 1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // T1: dual push, then single pop
    step(1, 32'hbfc0_0000, 5'd2, 32'h11, 1, 32'hbfc0_0004, 5'd3, 32'h22, 0, 0);
    check("t1_count", 64'(count), 64'd2);
    check("t1_pc0", 64'(out_pc), 64'hbfc0_0000);
    check("t1_order0", 64'(out_order), 64'd0);
    idle(1);
    check("t1_pc1", 64'(out_pc), 64'hbfc0_0004);
    check("t1_order1", 64'(out_order), 64'd1);
    idle(1);

    // T2: lane 1 only
    step(0, 32'h0, 5'd9, 32'h0, 1, 32'h1000, 5'd5, 32'h55, 1, 0);
    check("t2_order", 64'(out_order), 64'd1);
    check("t2_rd", 64'(out_rd), 64'd5);
    idle(1);
    check("t2_valid", 64'(out_valid), 64'd0);
    check("t2_count", 64'(count), 64'd0);

    // T3: fill, then overflow with a fifth pair
    repeat (4) rstep(1, 1, 0, 0);
    check("t3_full", 64'(count), 64'd8);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_ovf0", 64'(overflow), 64'd0);
    rstep(1, 1, 0, 0);
    check("t3_count", 64'(count), 64'd8);
    check("t3_ovf1", 64'(overflow), 64'd1);

    // T4: count 7, pair dropped while the pop proceeds
    idle(1);
    check("t4_c7", 64'(count), 64'd7);
    rstep(1, 1, 1, 0);
    check("t4_c6", 64'(count), 64'd6);
    check("t4_ovf", 64'(overflow), 64'd1);
    repeat (7) idle(1);

    // T5: steady 1-in/1-out across pointer wrap, overflow remains sticky
    repeat (3) rstep(1, 0, 0, 0);
    repeat (20) rstep(1, 0, 1, 0);
    check("t5_count", 64'(count), 64'd3);
    check("t5_ovf", 64'(overflow), 64'd1);
    repeat (4) idle(1);

    // T6: reset wins over a simultaneous push
    rstep(1, 1, 0, 0);
    rstep(1, 1, 0, 0);
    rstep(1, 0, 0, 0);
    check("t6_c5", 64'(count), 64'd5);
    rstep(1, 1, 1, 1);
    check("t6_count", 64'(count), 64'd0);
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);

    step(1, 32'h2000, 5'd0, 32'hAA, 1, 32'h2004, 5'd4, 32'hBB, 0, 0);
`ifdef WB_TRACE_SKIP_ZERO_EN
    check("zero_count", 64'(count), 64'd1);
    check("zero_rd", 64'(out_rd), 64'd4);
`else
    check("zero_count", 64'(count), 64'd2);
    check("zero_rd", 64'(out_rd), 64'd0);
`endif
    repeat (3) idle(1);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) == 0));
    end
    repeat (12) idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
